// File: rtl/control_pkg.sv
// Shared definitions for the multicycle control unit.
// Holds the instruction opcodes, ALU function codes, Bus B source codes,
// the FSM state encoding and the execution class that the decoder reports.
package control_pkg;

  // Instruction opcodes (top four bits of the instruction word)
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_ADDI  = 4'b0010;
  localparam logic [3:0] OP_SUBI  = 4'b0011;
  localparam logic [3:0] OP_MUL2  = 4'b0100;
  localparam logic [3:0] OP_DIV2  = 4'b0101;
  localparam logic [3:0] OP_CLR   = 4'b0110;
  localparam logic [3:0] OP_RST   = 4'b0111;
  localparam logic [3:0] OP_MOV   = 4'b1000;
  localparam logic [3:0] OP_JMP   = 4'b1001;
  localparam logic [3:0] OP_OUT   = 4'b1010;
  localparam logic [3:0] OP_LOAD  = 4'b1011;
  localparam logic [3:0] OP_STORE = 4'b1100;
  localparam logic [3:0] OP_JZ    = 4'b1101;
  localparam logic [3:0] OP_ILL   = 4'b1110;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  // ALU function selects
  localparam logic [3:0] G_ADD   = 4'b0000;
  localparam logic [3:0] G_SUB   = 4'b0001;
  localparam logic [3:0] G_MUL2  = 4'b0101;
  localparam logic [3:0] G_DIV2  = 4'b0110;
  localparam logic [3:0] G_PASSB = 4'b0111;

  // Bus B source selects
  localparam logic [1:0] MB_REG   = 2'b00;
  localparam logic [1:0] MB_CONST = 2'b01;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_e;

  // How an instruction leaves EXEC
  typedef enum logic [2:0] {
    CLS_STEP = 3'd0,  // one cycle, then pc+1
    CLS_MEM  = 3'd1,  // wait for mem_ready, then pc+1
    CLS_OUT  = 3'd2,  // wait for out_ready, then pc+1
    CLS_JMP  = 3'd3,  // one cycle, pc <- target
    CLS_JZ   = 3'd4,  // one cycle, pc <- target if zero_flag else pc+1
    CLS_HALT = 3'd5   // enter HALT
  } op_class_e;

  // Opcodes whose result is written from the ALU through Bus F
  function automatic logic is_alu_write(input logic [3:0] op);
    return (op == OP_ADD)  || (op == OP_SUB)  || (op == OP_ADDI) ||
           (op == OP_SUBI) || (op == OP_MUL2) || (op == OP_DIV2) ||
           (op == OP_CLR)  || (op == OP_MOV);
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of the latched instruction into a datapath control
// vector. Outputs are raw decode only; the top gates them with the FSM state
// and the handshake inputs.
// Ports: ir_i (instruction register) in; register selects, ALU/bus selects,
// immediate, memory/output strobes, write kinds, illegal flag, execution
// class and jump target out.
module instr_decoder
  import control_pkg::*;
#(
  parameter int REG_ADDR_W = 3,
  parameter int DATA_W     = 8,
  localparam int IW        = 4 + 2 * REG_ADDR_W
) (
  input  logic [IW-1:0]           ir_i,
  output logic [REG_ADDR_W-1:0]   reg_a_sel_o,
  output logic [REG_ADDR_W-1:0]   reg_b_sel_o,
  output logic                    alu_write_o,
  output logic                    load_write_o,
  output logic                    reg_reset_o,
  output logic [3:0]              g_sel_o,
  output logic [1:0]              mb_sel_o,
  output logic                    mf_sel_o,
  output logic                    md_sel_o,
  output logic [DATA_W-1:0]       const_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic                    out_valid_o,
  output logic                    illegal_o,
  output op_class_e               op_class_o,
  output logic [2*REG_ADDR_W-1:0] target_o
);

  logic [3:0]            op_s;
  logic [REG_ADDR_W-1:0] a_s;
  logic [REG_ADDR_W-1:0] b_s;
  logic                  alu_wr_s;

  assign op_s     = ir_i[IW-1:IW-4];
  assign a_s      = ir_i[2*REG_ADDR_W-1:REG_ADDR_W];
  assign b_s      = ir_i[REG_ADDR_W-1:0];
  assign alu_wr_s = is_alu_write(op_s);
  assign target_o = ir_i[2*REG_ADDR_W-1:0];

  // Opcode decode into selects, strobes and execution class
  always_comb begin
    reg_a_sel_o  = '0;
    reg_b_sel_o  = '0;
    load_write_o = 1'b0;
    reg_reset_o  = 1'b0;
    g_sel_o      = 4'b0000;
    mb_sel_o     = MB_REG;
    const_o      = '0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    out_valid_o  = 1'b0;
    illegal_o    = 1'b0;
    op_class_o   = CLS_STEP;
    case (op_s)
      OP_ADD: begin
        reg_a_sel_o = a_s;
        reg_b_sel_o = b_s;
        g_sel_o     = G_ADD;
      end
      OP_SUB: begin
        reg_a_sel_o = a_s;
        reg_b_sel_o = b_s;
        g_sel_o     = G_SUB;
      end
      OP_ADDI: begin
        reg_a_sel_o = a_s;
        g_sel_o     = G_ADD;
        mb_sel_o    = MB_CONST;
        const_o     = DATA_W'(b_s);
      end
      OP_SUBI: begin
        reg_a_sel_o = a_s;
        g_sel_o     = G_SUB;
        mb_sel_o    = MB_CONST;
        const_o     = DATA_W'(b_s);
      end
      OP_MUL2: begin
        reg_a_sel_o = a_s;
        g_sel_o     = G_MUL2;
      end
      OP_DIV2: begin
        reg_a_sel_o = a_s;
        g_sel_o     = G_DIV2;
      end
      OP_CLR: begin
        // PASSB of a zero immediate clears A
        reg_a_sel_o = a_s;
        g_sel_o     = G_PASSB;
        mb_sel_o    = MB_CONST;
      end
      OP_RST: begin
        reg_reset_o = 1'b1;
      end
      OP_MOV: begin
        reg_a_sel_o = a_s;
        reg_b_sel_o = b_s;
        g_sel_o     = G_PASSB;
      end
      OP_JMP: begin
        op_class_o = CLS_JMP;
      end
      OP_OUT: begin
        reg_a_sel_o = a_s;
        out_valid_o = 1'b1;
        op_class_o  = CLS_OUT;
      end
      OP_LOAD: begin
        // md_sel stays 0 so Bus D carries memory data
        reg_a_sel_o  = a_s;
        reg_b_sel_o  = b_s;
        mem_req_o    = 1'b1;
        load_write_o = 1'b1;
        op_class_o   = CLS_MEM;
      end
      OP_STORE: begin
        reg_a_sel_o = a_s;
        reg_b_sel_o = b_s;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        op_class_o  = CLS_MEM;
      end
      OP_JZ: begin
        op_class_o = CLS_JZ;
      end
      OP_ILL: begin
        illegal_o = 1'b1;
      end
      OP_HALT: begin
        op_class_o = CLS_HALT;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

  assign alu_write_o = alu_wr_s;
  assign mf_sel_o    = alu_wr_s;
  assign md_sel_o    = alu_wr_s;

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: fetches instructions over a valid/ready handshake,
// holds the program counter and instruction register, and sequences the
// datapath through FETCH/EXEC/HALT.
// Ports: clk/rst (sync, active-high); instr_req/instr_valid/instruction/pc
// fetch interface; zero_flag from the datapath; register selects, one-hot
// write_enable, reg_reset, ALU and bus selects, constant_in; mem_req/mem_we/
// mem_ready and out_valid/out_ready handshakes; illegal and halted status.
module multicycle_control_unit
  import control_pkg::*;
#(
  parameter int REG_ADDR_W = 3,
  parameter int DATA_W     = 8,
  parameter int PC_W       = 8,
  localparam int NUM_REGS  = 2 ** REG_ADDR_W,
  localparam int IW        = 4 + 2 * REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  instr_req,
  input  logic                  instr_valid,
  input  logic [IW-1:0]         instruction,
  output logic [PC_W-1:0]       pc,
  input  logic                  zero_flag,
  output logic [REG_ADDR_W-1:0] reg_a_select,
  output logic [REG_ADDR_W-1:0] reg_b_select,
  output logic [NUM_REGS-1:0]   write_enable,
  output logic                  reg_reset,
  output logic [3:0]            g_select,
  output logic [1:0]            mb_select,
  output logic                  mf_select,
  output logic                  md_select,
  output logic [DATA_W-1:0]     constant_in,
  output logic                  mem_req,
  output logic                  mem_we,
  input  logic                  mem_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  illegal,
  output logic                  halted
);

  state_e          state_q, state_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic [PC_W-1:0] pc_q, pc_d;

  logic [REG_ADDR_W-1:0]   dec_ra_s, dec_rb_s;
  logic                    dec_alu_wr_s, dec_load_wr_s, dec_rreset_s;
  logic [3:0]              dec_g_s;
  logic [1:0]              dec_mb_s;
  logic                    dec_mf_s, dec_md_s;
  logic [DATA_W-1:0]       dec_const_s;
  logic                    dec_mreq_s, dec_mwe_s, dec_oval_s, dec_ill_s;
  op_class_e               dec_class_s;
  logic [2*REG_ADDR_W-1:0] dec_target_s;

  logic [PC_W-1:0]     pc_inc_s;
  logic [PC_W-1:0]     pc_target_s;
  logic [NUM_REGS-1:0] dest_onehot_s;

  instr_decoder #(
    .REG_ADDR_W (REG_ADDR_W),
    .DATA_W     (DATA_W)
  ) u_decoder (
    .ir_i         (ir_q),
    .reg_a_sel_o  (dec_ra_s),
    .reg_b_sel_o  (dec_rb_s),
    .alu_write_o  (dec_alu_wr_s),
    .load_write_o (dec_load_wr_s),
    .reg_reset_o  (dec_rreset_s),
    .g_sel_o      (dec_g_s),
    .mb_sel_o     (dec_mb_s),
    .mf_sel_o     (dec_mf_s),
    .md_sel_o     (dec_md_s),
    .const_o      (dec_const_s),
    .mem_req_o    (dec_mreq_s),
    .mem_we_o     (dec_mwe_s),
    .out_valid_o  (dec_oval_s),
    .illegal_o    (dec_ill_s),
    .op_class_o   (dec_class_s),
    .target_o     (dec_target_s)
  );

  // pc_q + 1 wraps naturally at PC_W bits
  assign pc_inc_s      = pc_q + PC_W'(1);
  assign pc_target_s   = PC_W'(dec_target_s);
  // Destination comes from IR.A, never from the live select outputs
  assign dest_onehot_s = NUM_REGS'(1) << ir_q[2*REG_ADDR_W-1:REG_ADDR_W];

  // State, program counter and instruction register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state, next-pc and instruction latch
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      FETCH: begin
        if (instr_valid) begin
          ir_d    = instruction;
          state_d = EXEC;
        end else begin
          state_d = FETCH;
        end
      end
      EXEC: begin
        case (dec_class_s)
          CLS_STEP: begin
            pc_d    = pc_inc_s;
            state_d = FETCH;
          end
          CLS_MEM: begin
            if (mem_ready) begin
              pc_d    = pc_inc_s;
              state_d = FETCH;
            end else begin
              state_d = EXEC;
            end
          end
          CLS_OUT: begin
            if (out_ready) begin
              pc_d    = pc_inc_s;
              state_d = FETCH;
            end else begin
              state_d = EXEC;
            end
          end
          CLS_JMP: begin
            pc_d    = pc_target_s;
            state_d = FETCH;
          end
          CLS_JZ: begin
            if (zero_flag) begin
              pc_d = pc_target_s;
            end else begin
              pc_d = pc_inc_s;
            end
            state_d = FETCH;
          end
          CLS_HALT: begin
            state_d = HALT;
          end
          default: begin
            state_d = FETCH;
          end
        endcase
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Output decode: everything is zero outside the state that drives it
  always_comb begin
    instr_req    = 1'b0;
    pc           = '0;
    reg_a_select = '0;
    reg_b_select = '0;
    write_enable = '0;
    reg_reset    = 1'b0;
    g_select     = 4'b0000;
    mb_select    = 2'b00;
    mf_select    = 1'b0;
    md_select    = 1'b0;
    constant_in  = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    out_valid    = 1'b0;
    illegal      = 1'b0;
    halted       = 1'b0;
    case (state_q)
      FETCH: begin
        instr_req = 1'b1;
        pc        = pc_q;
      end
      EXEC: begin
        pc           = pc_q;
        reg_a_select = dec_ra_s;
        reg_b_select = dec_rb_s;
        reg_reset    = dec_rreset_s;
        g_select     = dec_g_s;
        mb_select    = dec_mb_s;
        mf_select    = dec_mf_s;
        md_select    = dec_md_s;
        constant_in  = dec_const_s;
        mem_req      = dec_mreq_s;
        mem_we       = dec_mwe_s;
        out_valid    = dec_oval_s;
        illegal      = dec_ill_s;
        // LOAD writes back only in the cycle the memory answers
        if (dec_alu_wr_s || (dec_load_wr_s && mem_ready)) begin
          write_enable = dest_onehot_s;
        end else begin
          write_enable = '0;
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        halted = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit (default parameters).
// A transaction-level model tracks the program counter and predicts every
// output in every cycle from the instruction semantics.
`timescale 1ns/1ps
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_req;
  logic       instr_valid;
  logic [9:0] instruction;
  logic [7:0] pc;
  logic       zero_flag;
  logic [2:0] reg_a_select, reg_b_select;
  logic [7:0] write_enable;
  logic       reg_reset;
  logic [3:0] g_select;
  logic [1:0] mb_select;
  logic       mf_select, md_select;
  logic [7:0] constant_in;
  logic       mem_req, mem_we, mem_ready;
  logic       out_valid, out_ready;
  logic       illegal, halted;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk          (clk),
    .rst          (rst),
    .instr_req    (instr_req),
    .instr_valid  (instr_valid),
    .instruction  (instruction),
    .pc           (pc),
    .zero_flag    (zero_flag),
    .reg_a_select (reg_a_select),
    .reg_b_select (reg_b_select),
    .write_enable (write_enable),
    .reg_reset    (reg_reset),
    .g_select     (g_select),
    .mb_select    (mb_select),
    .mf_select    (mf_select),
    .md_select    (md_select),
    .constant_in  (constant_in),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_ready    (mem_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .illegal      (illegal),
    .halted       (halted)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic       instr_req;
    logic [7:0] pc;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [7:0] we;
    logic       rr;
    logic [3:0] g;
    logic [1:0] mb;
    logic       mf;
    logic       md;
    logic [7:0] cin;
    logic       mreq;
    logic       mwe;
    logic       oval;
    logic       ill;
    logic       halted;
  } obs_t;

  logic [7:0] model_pc;

  task automatic check_obs(input string tag, input obs_t e);
    check_eq({tag, ".instr_req"}, instr_req, e.instr_req);
    check_eq({tag, ".pc"}, pc, e.pc);
    check_eq({tag, ".reg_a_select"}, reg_a_select, e.ra);
    check_eq({tag, ".reg_b_select"}, reg_b_select, e.rb);
    check_eq({tag, ".write_enable"}, write_enable, e.we);
    check_eq({tag, ".reg_reset"}, reg_reset, e.rr);
    check_eq({tag, ".g_select"}, g_select, e.g);
    check_eq({tag, ".mb_select"}, mb_select, e.mb);
    check_eq({tag, ".mf_select"}, mf_select, e.mf);
    check_eq({tag, ".md_select"}, md_select, e.md);
    check_eq({tag, ".constant_in"}, constant_in, e.cin);
    check_eq({tag, ".mem_req"}, mem_req, e.mreq);
    check_eq({tag, ".mem_we"}, mem_we, e.mwe);
    check_eq({tag, ".out_valid"}, out_valid, e.oval);
    check_eq({tag, ".illegal"}, illegal, e.ill);
    check_eq({tag, ".halted"}, halted, e.halted);
  endtask

  function automatic obs_t idle_exp();
    obs_t e = '0;
    e.instr_req = 1'b1;
    e.pc        = model_pc;
    return e;
  endfunction

  function automatic obs_t halt_exp();
    obs_t e = '0;
    e.halted = 1'b1;
    return e;
  endfunction

  // Expected EXEC-cycle outputs straight from the instruction semantics
  function automatic obs_t exec_exp(input logic [9:0] ins, input bit mrdy);
    obs_t       e = '0;
    int         op = int'(ins[9:6]);
    logic [2:0] a  = ins[5:3];
    logic [2:0] b  = ins[2:0];
    bit         alu = 1'b0;
    e.pc = model_pc;
    case (op)
      0:  begin alu = 1; e.g = 4'd0; e.ra = a; e.rb = b; end
      1:  begin alu = 1; e.g = 4'd1; e.ra = a; e.rb = b; end
      2:  begin alu = 1; e.g = 4'd0; e.ra = a; e.mb = 2'b01; e.cin = {5'd0, b}; end
      3:  begin alu = 1; e.g = 4'd1; e.ra = a; e.mb = 2'b01; e.cin = {5'd0, b}; end
      4:  begin alu = 1; e.g = 4'd5; e.ra = a; end
      5:  begin alu = 1; e.g = 4'd6; e.ra = a; end
      6:  begin alu = 1; e.g = 4'd7; e.ra = a; e.mb = 2'b01; e.cin = 8'd0; end
      7:  e.rr = 1'b1;
      8:  begin alu = 1; e.g = 4'd7; e.ra = a; e.rb = b; end
      10: begin e.ra = a; e.oval = 1'b1; end
      11: begin
            e.ra = a; e.rb = b; e.mreq = 1'b1;
            e.we = mrdy ? (8'd1 << a) : 8'd0;
          end
      12: begin e.ra = a; e.rb = b; e.mreq = 1'b1; e.mwe = 1'b1; end
      14: e.ill = 1'b1;
      default: e.ill = 1'b0;
    endcase
    if (alu) begin
      e.mf = 1'b1;
      e.md = 1'b1;
      e.we = 8'd1 << a;
    end
    return e;
  endfunction

  // Fetch and execute one instruction. Entry/exit at posedge+1, FETCH state.
  // abort_at >= 0 asserts rst in that wait cycle of a handshake instruction.
  task automatic run_instr(input logic [9:0] ins, input int gap, input int wait_n,
                           input bit zf, input int abort_at);
    int op = int'(ins[9:6]);
    for (int i = 0; i < gap; i++) begin
      instr_valid = 1'b0;
      instruction = 10'($urandom);
      #2 check_obs("fetch_wait", idle_exp());
      @(posedge clk); #1;
    end
    instr_valid = 1'b1;
    instruction = ins;
    #2 check_obs("fetch", idle_exp());
    @(posedge clk); #1;
    // IR alone must drive EXEC, so scramble the fetch bus
    instr_valid = 1'($urandom);
    instruction = 10'($urandom);
    zero_flag   = zf;
    if (op == 10 || op == 11 || op == 12) begin
      for (int w = 0; w < wait_n; w++) begin
        mem_ready = (op == 10) ? 1'($urandom) : 1'b0;
        out_ready = (op == 10) ? 1'b0 : 1'($urandom);
        if (w == abort_at) begin
          // rst wins even though the matching ready is raised too
          rst = 1'b1;
          if (op == 10) out_ready = 1'b1; else mem_ready = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0; instr_valid = 1'b0; mem_ready = 1'b0; out_ready = 1'b0;
          model_pc = 8'd0;
          #2 check_obs("after_rst", idle_exp());
          @(posedge clk); #1;
          return;
        end
        #2 check_obs($sformatf("wait_op%0d", op), exec_exp(ins, 1'b0));
        @(posedge clk); #1;
      end
      if (op == 10) begin
        out_ready = 1'b1; mem_ready = 1'b0;
      end else begin
        mem_ready = 1'b1; out_ready = 1'b0;
      end
      #2 check_obs($sformatf("done_op%0d", op), exec_exp(ins, 1'b1));
    end else begin
      mem_ready = 1'($urandom);
      out_ready = 1'($urandom);
      #2 check_obs($sformatf("exec_op%0d", op), exec_exp(ins, mem_ready));
    end
    @(posedge clk); #1;
    mem_ready   = 1'b0;
    out_ready   = 1'b0;
    instr_valid = 1'b0;
    case (op)
      9:  model_pc = {2'b00, ins[5:0]};
      13: model_pc = zf ? {2'b00, ins[5:0]} : model_pc + 8'd1;
      15: model_pc = model_pc;
      default: model_pc = model_pc + 8'd1;
    endcase
  endtask

  initial begin
    int guard;
    rst = 1'b1; instr_valid = 1'b0; instruction = 10'd0;
    zero_flag = 1'b0; mem_ready = 1'b0; out_ready = 1'b0;
    model_pc = 8'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #2 check_obs("reset", idle_exp());
    @(posedge clk); #1;

    // ADD r2,r5 then ADDI r3,#6
    run_instr(10'b0000_010_101, 0, 0, 1'b0, -1);
    check_eq("pc_after_add", pc, 32'd1);
    run_instr(10'b0010_011_110, 0, 0, 1'b0, -1);
    // LOAD r1,[r4] with ready after 3 wait cycles
    run_instr(10'b1011_001_100, 1, 3, 1'b0, -1);
    check_eq("pc_after_load", pc, 32'd3);
    // STORE completes, OUT is held then reset mid-wait
    run_instr(10'b1100_010_011, 0, 2, 1'b0, -1);
    run_instr(10'b1010_101_000, 0, 4, 1'b0, 3);
    check_eq("pc_after_abort", pc, 32'd0);
    // STORE aborted by reset in its first EXEC cycle
    run_instr(10'b0000_001_001, 0, 0, 1'b0, -1);
    run_instr(10'b1100_111_000, 0, 2, 1'b0, 0);
    // Illegal opcode, JZ not taken, JZ taken
    run_instr(10'b1110_011_011, 0, 0, 1'b0, -1);
    run_instr(10'b1101_010_000, 0, 0, 1'b0, -1);
    check_eq("jz_not_taken", pc, 32'd2);
    run_instr(10'b1101_010_000, 0, 0, 1'b1, -1);
    check_eq("jz_taken", pc, 32'h10);

    // Walk to 0xFE, jump to 0x3F, walk to 0xFF, wrap to 0
    guard = 0;
    while (model_pc != 8'hFE && guard < 300) begin
      run_instr({4'b0000, 6'($urandom)}, 0, 0, 1'b0, -1);
      guard++;
    end
    check_eq("reach_fe", pc, 32'hFE);
    run_instr(10'b1001_111_111, 0, 0, 1'b0, -1);
    check_eq("jmp_3f", pc, 32'h3F);
    guard = 0;
    while (model_pc != 8'hFF && guard < 300) begin
      run_instr({4'b0111, 6'($urandom)}, 0, 0, 1'b0, -1);
      guard++;
    end
    check_eq("reach_ff", pc, 32'hFF);
    run_instr(10'b0001_000_111, 0, 0, 1'b0, -1);
    check_eq("pc_wrap", pc, 32'd0);

    // Random instruction stream (no HALT), occasional reset aborts
    for (int n = 0; n < 150; n++) begin
      logic [3:0] op;
      int         wn;
      int         ab;
      op = 4'($urandom_range(0, 14));
      wn = $urandom_range(0, 3);
      ab = -1;
      if ((op == 4'd10 || op == 4'd11 || op == 4'd12) && wn > 0 &&
          $urandom_range(0, 9) == 0) begin
        ab = $urandom_range(0, wn - 1);
      end
      run_instr({op, 6'($urandom)}, $urandom_range(0, 2), wn, 1'($urandom), ab);
    end

    // HALT: stays put whatever the inputs do, until rst
    run_instr(10'b1111_000_000, 0, 0, 1'b0, -1);
    for (int i = 0; i < 4; i++) begin
      instr_valid = 1'b1; instruction = 10'($urandom);
      mem_ready = 1'b1; out_ready = 1'b1;
      #2 check_obs("halt", halt_exp());
      @(posedge clk); #1;
    end
    rst = 1'b1; instr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0; out_ready = 1'b0;
    model_pc = 8'd0;
    #2 check_obs("halt_rst", idle_exp());
    @(posedge clk); #1;
    run_instr(10'b1000_110_001, 0, 0, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
